riscv_decode_stage: RTL and testbench

Registered instruction-decode stage for the integer core: accepts one 32-bit RV32I instruction and its PC per handshake from fetch. Decodes OP, OP-IMM, LUI and AUIPC into an `alu_op_t` control bundle, register indices and an immediate. Presents the result one cycle later to the execute stage (ALU) through a valid/ready pipeline register with stall and flush support.

---
 rtl/riscv_decode_stage_pkg.sv | 54 +++++
 rtl/riscv_decode_stage_if.sv | 35 +++
 rtl/riscv_decode_stage_alu_decoder.sv | 78 +++++++
 rtl/riscv_decode_stage.sv | 63 ++++++
 tb/tb_riscv_decode_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_decode_stage_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU operation encoding and
// the decoded control bundle handed to execute.
package riscv_decode_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef struct packed {
    alu_op_t         alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            src_a_pc;
    logic            reg_write;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } decode_bundle_t;

  // alt selects SUB/SRA; it is ignored for every other funct3.
  function automatic alu_op_t f3_to_alu_op(logic [2:0] f3, logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface riscv_decode_stage_if #(parameter int XLEN = 32);
  import riscv_decode_stage_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  alu_op_t         out_alu_op;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_use_imm;
  logic            out_src_a_pc;
  logic            out_reg_write;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd, out_imm,
           out_use_imm, out_src_a_pc, out_reg_write, out_illegal, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd, out_imm,
           out_use_imm, out_src_a_pc, out_reg_write, out_illegal, out_pc
  );

endinterface

// File: rtl/riscv_decode_stage_alu_decoder.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC. Anything else
// (or a bad funct7) yields a zeroed bundle flagged illegal, PC preserved.
module riscv_alu_decoder
  import riscv_decode_stage_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output decode_bundle_t  bundle_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rd;
  logic       legal;
  logic       is_shift;

  assign opc      = instr_i[6:0];
  assign rd       = instr_i[11:7];
  assign f3       = instr_i[14:12];
  assign rs1      = instr_i[19:15];
  assign rs2      = instr_i[24:20];
  assign f7       = instr_i[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    bundle_o    = '0;
    bundle_o.pc = pc_i;
    legal       = 1'b0;
    case (opc)
      OPC_OP: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        bundle_o.alu_op = f3_to_alu_op(f3, f7[5]);
        bundle_o.rs1    = rs1;
        bundle_o.rs2    = rs2;
        bundle_o.rd     = rd;
      end
      OPC_OP_IMM: begin
        bundle_o.rs1     = rs1;
        bundle_o.rd      = rd;
        bundle_o.use_imm = 1'b1;
        if (is_shift) begin
          legal = (f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20);
          bundle_o.alu_op = f3_to_alu_op(f3, f7[5]);
          bundle_o.imm    = {27'b0, instr_i[24:20]};
        end else begin
          // No SUBI: funct3 000 is always ADD regardless of the upper bits.
          legal = 1'b1;
          bundle_o.alu_op = f3_to_alu_op(f3, 1'b0);
          bundle_o.imm    = {{20{instr_i[31]}}, instr_i[31:20]};
        end
      end
      OPC_LUI: begin
        legal            = 1'b1;
        bundle_o.rd      = rd;
        bundle_o.imm     = {instr_i[31:12], 12'b0};
        bundle_o.use_imm = 1'b1;
      end
      OPC_AUIPC: begin
        legal             = 1'b1;
        bundle_o.rs1      = rs1;
        bundle_o.rd       = rd;
        bundle_o.imm      = {instr_i[31:12], 12'b0};
        bundle_o.use_imm  = 1'b1;
        bundle_o.src_a_pc = 1'b1;
      end
      default: ;
    endcase

    if (!legal) begin
      bundle_o         = '0;
      bundle_o.pc      = pc_i;
      bundle_o.illegal = 1'b1;
    end
    bundle_o.reg_write = legal && (rd != 5'd0);
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode stage: one valid/ready pipeline register in front of execute; flush
// wins over accept, accept wins over drain.
module riscv_decode_stage
  import riscv_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  riscv_decode_stage_if.slave    bus
);

  decode_bundle_t dec;
  decode_bundle_t payload_q, payload_d;
  logic           out_valid_q, out_valid_d;
  logic           accept;

  riscv_alu_decoder u_dec (
    .instr_i  (bus.in_instr),
    .pc_i     (bus.in_pc),
    .bundle_o (dec)
  );

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      payload_d   = dec;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_alu_op    = payload_q.alu_op;
  assign bus.out_rs1       = payload_q.rs1;
  assign bus.out_rs2       = payload_q.rs2;
  assign bus.out_rd        = payload_q.rd;
  assign bus.out_imm       = payload_q.imm[XLEN-1:0];
  assign bus.out_use_imm   = payload_q.use_imm;
  assign bus.out_src_a_pc  = payload_q.src_a_pc;
  assign bus.out_reg_write = payload_q.reg_write;
  assign bus.out_illegal   = payload_q.illegal;
  assign bus.out_pc        = payload_q.pc[XLEN-1:0];

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed and random checks of riscv_decode_stage against a rule-level model.
module tb_riscv_decode_stage;
  import riscv_decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  riscv_decode_stage_if bus ();

  riscv_decode_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  decode_bundle_t got;
  always_comb got = '{alu_op: bus.out_alu_op, rs1: bus.out_rs1, rs2: bus.out_rs2,
                      rd: bus.out_rd, imm: bus.out_imm, use_imm: bus.out_use_imm,
                      src_a_pc: bus.out_src_a_pc, reg_write: bus.out_reg_write,
                      illegal: bus.out_illegal, pc: bus.out_pc};

  bit             mvalid;
  decode_bundle_t mpay;

  function automatic decode_bundle_t ref_decode(logic [31:0] w, logic [31:0] pc);
    decode_bundle_t    r;
    logic signed [31:0] s;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    bit ok = 0;
    alu_op_t tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    r = '0;
    r.pc = pc;
    if (opc == 7'h33) begin
      ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      r.alu_op = tab[f3];
      if (f7 == 7'h20 && f3 == 0) r.alu_op = ALU_SUB;
      if (f7 == 7'h20 && f3 == 5) r.alu_op = ALU_SRA;
      r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
    end else if (opc == 7'h13) begin
      r.rs1 = w[19:15]; r.rd = w[11:7]; r.use_imm = 1;
      r.alu_op = tab[f3];
      if (f3 == 1 || f3 == 5) begin
        ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
        r.imm = 32'(w[24:20]);
        if (f3 == 5 && f7 == 7'h20) r.alu_op = ALU_SRA;
      end else begin
        ok = 1;
        s = $signed(w[31:20]);
        r.imm = s;
      end
    end else if (opc == 7'h37 || opc == 7'h17) begin
      ok = 1;
      r.rd = w[11:7]; r.imm = w & 32'hFFFF_F000; r.use_imm = 1;
      if (opc == 7'h17) begin r.src_a_pc = 1; r.rs1 = w[19:15]; end
    end
    if (!ok) begin
      r = '0; r.pc = pc; r.illegal = 1;
    end else begin
      r.reg_write = (r.rd != 0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // One clock: advance the model at the edge, compare everything at the falling edge.
  task automatic cycle();
    bit acc;
    @(posedge clk);
    acc = bus.in_valid && (!mvalid || bus.out_ready);
    if (flush) mvalid = 0;
    else if (acc) begin mvalid = 1; mpay = ref_decode(bus.in_instr, bus.in_pc); end
    else if (mvalid && bus.out_ready) mvalid = 0;
    @(negedge clk);
    chk("out_valid", bus.out_valid, mvalid);
    chk("in_ready", bus.in_ready, !mvalid || bus.out_ready);
    chk("payload", got, mpay);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    mvalid = 0;
    mpay   = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_payload", got, '0);
    chk("rst_aluop", bus.out_alu_op, ALU_ADD);
    rst = 1'b0;

    drive(1, 32'h002081B3, 32'h0, 1, 0); cycle();
    chk("add_op", bus.out_alu_op, ALU_ADD);
    chk("add_rs1", bus.out_rs1, 5'd1);
    chk("add_rs2", bus.out_rs2, 5'd2);
    chk("add_rd", bus.out_rd, 5'd3);
    chk("add_rw", bus.out_reg_write, 1'b1);
    chk("add_ui", bus.out_use_imm, 1'b0);

    drive(1, 32'h402081B3, 32'h4, 1, 0); cycle();
    chk("sub_op", bus.out_alu_op, ALU_SUB);
    drive(1, 32'h40335293, 32'h8, 1, 0); cycle();
    chk("srai_op", bus.out_alu_op, ALU_SRA);
    chk("srai_rs1", bus.out_rs1, 5'd6);
    chk("srai_rd", bus.out_rd, 5'd5);
    chk("srai_imm", bus.out_imm, 32'd3);
    chk("srai_ui", bus.out_use_imm, 1'b1);

    drive(1, 32'hFFF00093, 32'hC, 1, 0); cycle();
    chk("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
    chk("addi_op", bus.out_alu_op, ALU_ADD);
    drive(1, 32'h123452B7, 32'h10, 1, 0); cycle();
    chk("lui_imm", bus.out_imm, 32'h1234_5000);
    chk("lui_rs1", bus.out_rs1, 5'd0);
    drive(1, 32'h00001197, 32'h100, 1, 0); cycle();
    chk("auipc_srca", bus.out_src_a_pc, 1'b1);
    chk("auipc_pc", bus.out_pc, 32'h100);

    drive(1, 32'h0000007F, 32'h104, 1, 0); cycle();
    chk("ill_flag", bus.out_illegal, 1'b1);
    chk("ill_rw", bus.out_reg_write, 1'b0);
    drive(1, 32'h022081B3, 32'h108, 1, 0); cycle();
    chk("ill7_flag", bus.out_illegal, 1'b1);
    chk("ill7_op", bus.out_alu_op, ALU_ADD);
    chk("ill7_rd", bus.out_rd, 5'd0);

    // Stall: A held while B waits for three cycles, then both move in order.
    drive(0, 0, 0, 1, 0); cycle();
    drive(1, 32'h00208233, 32'h200, 0, 0); cycle();
    drive(1, 32'h00500313, 32'h204, 0, 0);
    repeat (3) begin
      cycle();
      chk("stall_rd", bus.out_rd, 5'd4);
      chk("stall_rdy", bus.in_ready, 1'b0);
    end
    drive(1, 32'h00500313, 32'h204, 1, 0); cycle();
    chk("release_rd", bus.out_rd, 5'd6);
    drive(0, 0, 0, 1, 0); cycle();
    chk("release_drain", bus.out_valid, 1'b0);

    drive(1, 32'h00208233, 32'h300, 0, 0); cycle();
    drive(0, 0, 0, 0, 1); cycle();
    chk("flush_stalled", bus.out_valid, 1'b0);
    drive(1, 32'h00208233, 32'h304, 1, 1); cycle();
    chk("flush_incoming", bus.out_valid, 1'b0);

    drive(1, 32'h00208233, 32'h308, 0, 0); cycle();
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 mvalid = 0; mpay = '0;
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_payload", got, '0);
    #1 rst = 1'b0;
    cycle();
    chk("rst_no_replay", bus.out_valid, 1'b0);

    repeat (400) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: w[6:0] = 7'h33;
        1: w[6:0] = 7'h13;
        2: w[6:0] = 7'h37;
        3: w[6:0] = 7'h17;
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, w, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
